// File: rtl/datapath_seq_if.sv
// rtl/datapath_seq_if.sv - controller-side op/handshake/status bundle for datapath_seq
interface datapath_seq_if #(
    parameter int W     = 16,
    parameter int NREGS = 8,
    parameter int PCW   = 8
);
    localparam int AW = $clog2(NREGS);

    logic           start;
    logic [AW-1:0]  rn;
    logic [AW-1:0]  rm;
    logic [AW-1:0]  rd;
    logic [1:0]     aluop;
    logic [1:0]     shift;
    logic           asel;
    logic           bsel;
    logic [1:0]     vsel;
    logic           wr;
    logic           loads;
    logic [W-1:0]   sximm5;
    logic [W-1:0]   sximm8;
    logic [W-1:0]   mdata;
    logic [PCW-1:0] PC;
    logic           busy;
    logic           done;
    logic [W-1:0]   datapath_out;
    logic [2:0]     ZNV_out;
    logic [AW-1:0]  dbg_addr;
    logic [W-1:0]   dbg_data;

    modport master (
        output start, rn, rm, rd, aluop, shift, asel, bsel, vsel, wr, loads,
               sximm5, sximm8, mdata, PC, dbg_addr,
        input  busy, done, datapath_out, ZNV_out, dbg_data
    );

    modport slave (
        input  start, rn, rm, rd, aluop, shift, asel, bsel, vsel, wr, loads,
               sximm5, sximm8, mdata, PC, dbg_addr,
        output busy, done, datapath_out, ZNV_out, dbg_data
    );
endinterface

// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - self-sequencing regfile/shifter/ALU datapath, one op per start pulse
module datapath_seq #(
    parameter int W     = 16,
    parameter int NREGS = 8,
    parameter int PCW   = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    datapath_seq_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic [2:0] {IDLE, LA, LB, EX, WB} state_t;

    state_t         state;
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   regs [NREGS];
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   c_q;
    logic [2:0]     znv_q;

    // Op fields captured at the accepting edge; bus values are ignored afterwards.
    logic [AW-1:0]  rn_q;
    logic [AW-1:0]  rm_q;
    logic [AW-1:0]  rd_q;
    logic [1:0]     aluop_q;
    logic [1:0]     shift_q;
    logic           asel_q;
    logic           bsel_q;
    logic [1:0]     vsel_q;
    logic           wr_q;
    logic           loads_q;
    logic [W-1:0]   sximm5_q;
    logic [W-1:0]   sximm8_q;

    logic [W-1:0]   b_sh;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_res;
    logic           alu_v;
    logic [W-1:0]   wb_val;

    // Shifter on B, operand selection, ALU and overflow detection.
    always_comb begin
        b_sh    = b_q;
        alu_res = '0;
        alu_v   = 1'b0;
        case (shift_q)
            2'b01:   b_sh = {b_q[W-2:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_q[W-1:1]};
            2'b11:   b_sh = {b_q[W-1], b_q[W-1:1]};
            default: b_sh = b_q;
        endcase
        alu_a = asel_q ? '0 : a_q;
        alu_b = bsel_q ? sximm5_q : b_sh;
        case (aluop_q)
            2'b00: begin
                alu_res = alu_a + alu_b;
                alu_v   = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
            end
            2'b01: begin
                alu_res = alu_a + ~alu_b + 1'b1;
                alu_v   = (alu_a[W-1] != alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
            end
            2'b10:   alu_res = alu_a & alu_b;
            default: alu_res = ~alu_b;
        endcase
    end

    // Writeback source; mdata and PC are taken live at the WB edge.
    always_comb begin
        case (vsel_q)
            2'b00:   wb_val = bus.mdata;
            2'b01:   wb_val = sximm8_q;
            2'b10:   wb_val = {{(W-PCW){1'b0}}, bus.PC};
            default: wb_val = c_q;
        endcase
    end

    // Sequencer: IDLE -> LA -> LB -> EX -> WB, plus all datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            znv_q    <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            rd_q     <= '0;
            aluop_q  <= '0;
            shift_q  <= '0;
            asel_q   <= 1'b0;
            bsel_q   <= 1'b0;
            vsel_q   <= '0;
            wr_q     <= 1'b0;
            loads_q  <= 1'b0;
            sximm5_q <= '0;
            sximm8_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rn_q     <= bus.rn;
                        rm_q     <= bus.rm;
                        rd_q     <= bus.rd;
                        aluop_q  <= bus.aluop;
                        shift_q  <= bus.shift;
                        asel_q   <= bus.asel;
                        bsel_q   <= bus.bsel;
                        vsel_q   <= bus.vsel;
                        wr_q     <= bus.wr;
                        loads_q  <= bus.loads;
                        sximm5_q <= bus.sximm5;
                        sximm8_q <= bus.sximm8;
                        busy_q   <= 1'b1;
                        state    <= LA;
                    end
                end
                LA: begin
                    a_q   <= regs[rn_q];
                    state <= LB;
                end
                LB: begin
                    b_q   <= regs[rm_q];
                    state <= EX;
                end
                EX: begin
                    c_q <= alu_res;
                    if (loads_q) begin
                        znv_q <= {(alu_res == '0), alu_res[W-1], alu_v};
                    end
                    state <= WB;
                end
                WB: begin
                    if (wr_q) begin
                        regs[rd_q] <= wb_val;
                    end
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.datapath_out = c_q;
    assign bus.ZNV_out      = znv_q;
    assign bus.dbg_data     = regs[bus.dbg_addr];
endmodule

// File: tb/tb_datapath_seq.sv
// tb/tb_datapath_seq.sv - directed self-checking bench for datapath_seq
module tb_datapath_seq;
    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    datapath_seq_if #(.W(16), .NREGS(8), .PCW(8)) dp ();

    datapath_seq #(.W(16), .NREGS(8), .PCW(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd_reg(input logic [2:0] r, output logic [15:0] v);
        dp.dbg_addr = r;
        #1;
        v = dp.dbg_data;
    endtask

    // Issues one op and waits for done; lat = edges after the accepting edge until done seen.
    task automatic do_op(input logic [2:0] rn_i, input logic [2:0] rm_i, input logic [2:0] rd_i,
                         input logic [1:0] aluop_i, input logic [1:0] shift_i,
                         input logic asel_i, input logic bsel_i, input logic [1:0] vsel_i,
                         input logic wr_i, input logic loads_i,
                         input logic [15:0] imm5, input logic [15:0] imm8, output int lat);
        @(negedge clk);
        dp.rn = rn_i; dp.rm = rm_i; dp.rd = rd_i; dp.aluop = aluop_i; dp.shift = shift_i;
        dp.asel = asel_i; dp.bsel = bsel_i; dp.vsel = vsel_i; dp.wr = wr_i; dp.loads = loads_i;
        dp.sximm5 = imm5; dp.sximm8 = imm8; dp.start = 1'b1;
        @(posedge clk);
        #1;
        dp.start = 1'b0;
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (dp.done) begin
                lat = i;
                break;
            end
        end
        if (lat == 99) chk("done_timeout", 32'd99, 32'd4);
    endtask

    task automatic load_imm(input logic [2:0] rd_i, input logic [15:0] v);
        int lat;
        do_op(3'd0, 3'd0, rd_i, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 16'h0, v, lat);
    endtask

    initial begin
        int          lat;
        logic [15:0] v;
        int          ndone;
        int          e1;
        int          e2;

        reset_n = 1'b0;
        dp.start = 0; dp.rn = 0; dp.rm = 0; dp.rd = 0; dp.aluop = 0; dp.shift = 0;
        dp.asel = 0; dp.bsel = 0; dp.vsel = 0; dp.wr = 0; dp.loads = 0;
        dp.sximm5 = 0; dp.sximm8 = 0; dp.mdata = 0; dp.PC = 0; dp.dbg_addr = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out", {16'h0, dp.datapath_out}, 32'h0);
        chk("rst_znv", {29'h0, dp.ZNV_out}, 32'h0);
        chk("rst_done", {31'h0, dp.done}, 32'h0);
        chk("rst_busy", {31'h0, dp.busy}, 32'h0);
        for (int r = 0; r < 8; r++) begin
            rd_reg(r[2:0], v);
            chk($sformatf("rst_r%0d", r), {16'h0, v}, 32'h0);
        end
        reset_n = 1'b1;

        // Load immediate and latency
        do_op(3'd0, 3'd0, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 16'h0, 16'hFF85, lat);
        chk("ld_lat", lat, 32'd4);
        chk("ld_busy", {31'h0, dp.busy}, 32'h0);
        rd_reg(3'd3, v);
        chk("ld_r3", {16'h0, v}, 32'h0000FF85);

        // ADD overflow 7FFF + 0001
        load_imm(3'd1, 16'h7FFF);
        load_imm(3'd2, 16'h0001);
        do_op(3'd1, 3'd2, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 16'h0, 16'h0, lat);
        rd_reg(3'd4, v);
        chk("add_r4", {16'h0, v}, 32'h8000);
        chk("add_c", {16'h0, dp.datapath_out}, 32'h8000);
        chk("add_znv", {29'h0, dp.ZNV_out}, 32'b011);

        // SUB with LSL1 on B: 8 - (4<<1) = 0
        load_imm(3'd5, 16'h0008);
        load_imm(3'd6, 16'h0004);
        do_op(3'd5, 3'd6, 3'd0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 16'h0, 16'h0, lat);
        chk("sub_c", {16'h0, dp.datapath_out}, 32'h0000);
        chk("sub_znv", {29'h0, dp.ZNV_out}, 32'b100);

        // LSR1 / ASR1 of 8000 with A forced to 0
        do_op(3'd0, 3'd4, 3'd7, 2'b00, 2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 16'h0, 16'h0, lat);
        chk("lsr_c", {16'h0, dp.datapath_out}, 32'h4000);
        chk("lsr_znv", {29'h0, dp.ZNV_out}, 32'b000);
        do_op(3'd0, 3'd4, 3'd7, 2'b00, 2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 16'h0, 16'h0, lat);
        rd_reg(3'd7, v);
        chk("asr_r7", {16'h0, v}, 32'hC000);
        chk("asr_znv", {29'h0, dp.ZNV_out}, 32'b010);

        // SUB overflow 8000 - 0001
        do_op(3'd4, 3'd2, 3'd5, 2'b01, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 16'h0, 16'h0, lat);
        rd_reg(3'd5, v);
        chk("subv_r5", {16'h0, v}, 32'h7FFF);
        chk("subv_znv", {29'h0, dp.ZNV_out}, 32'b001);

        // AND without status update, no write
        do_op(3'd1, 3'd2, 3'd3, 2'b10, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 16'h0, 16'h0, lat);
        chk("and_c", {16'h0, dp.datapath_out}, 32'h0001);
        chk("and_znv_hold", {29'h0, dp.ZNV_out}, 32'b001);
        rd_reg(3'd3, v);
        chk("nowr_r3", {16'h0, v}, 32'hFF85);

        // MVN of 0001
        do_op(3'd1, 3'd2, 3'd6, 2'b11, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 16'h0, 16'h0, lat);
        rd_reg(3'd6, v);
        chk("mvn_r6", {16'h0, v}, 32'hFFFE);
        chk("mvn_znv", {29'h0, dp.ZNV_out}, 32'b010);

        // Immediate B operand: 7FFF + sximm5 0001
        do_op(3'd1, 3'd0, 3'd0, 2'b00, 2'b01, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 16'h0001, 16'h0, lat);
        chk("imm5_c", {16'h0, dp.datapath_out}, 32'h8000);
        chk("imm5_znv", {29'h0, dp.ZNV_out}, 32'b011);

        // mdata and PC writeback
        dp.mdata = 16'hABCD;
        dp.PC    = 8'h5A;
        do_op(3'd0, 3'd0, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 16'h0, 16'h0, lat);
        rd_reg(3'd2, v);
        chk("mdata_r2", {16'h0, v}, 32'hABCD);
        do_op(3'd0, 3'd0, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 16'h0, 16'h0, lat);
        rd_reg(3'd1, v);
        chk("pc_r1", {16'h0, v}, 32'h005A);

        // Handshake: start held across two op periods, extra starts while busy ignored
        @(negedge clk);
        dp.rd = 3'd0; dp.vsel = 2'b01; dp.wr = 1'b1; dp.loads = 1'b0; dp.sximm8 = 16'h0011;
        dp.start = 1'b1;
        ndone = 0; e1 = -1; e2 = -1;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            #1;
            if (e == 9) dp.start = 1'b0;
            if (dp.done) begin
                ndone++;
                if (e1 < 0) e1 = e; else e2 = e;
            end
        end
        chk("hs_ndone", ndone, 32'd2);
        chk("hs_first", e1, 32'd4);
        chk("hs_second", e2, 32'd9);
        chk("hs_busy", {31'h0, dp.busy}, 32'h0);

        // Abort: reset during EX of a write to R7
        @(negedge clk);
        dp.rd = 3'd7; dp.vsel = 2'b01; dp.wr = 1'b1; dp.sximm8 = 16'h1234; dp.start = 1'b1;
        @(posedge clk);
        #1;
        dp.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("ab_busy_ex", {31'h0, dp.busy}, 32'h1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("ab_busy", {31'h0, dp.busy}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            if (dp.done) ndone++;
        end
        chk("ab_nodone", ndone, 32'd0);
        rd_reg(3'd7, v);
        chk("ab_r7", {16'h0, v}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
